// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and limits for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned CNT_W       = 2;
    localparam int unsigned MEM_LAT_MIN = 1;
    localparam int unsigned MEM_LAT_MAX = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory with fixed latency.
// Define MEMARB_RR_EN to resolve contention round-robin instead of data-over-fetch priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // Out-of-range latencies are clamped to the legal window.
    localparam int unsigned LAT_CLAMP =
        (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
        (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT_CLAMP - MEM_LAT_MIN);

    state_e           state;
    owner_e           owner;
    logic [CNT_W-1:0] cnt;
    mem_cmd_t         cmd;
    logic             grant_d_c;

`ifdef MEMARB_RR_EN
    owner_e last_grant;

    // Data wins alone, or on contention when fetch was granted most recently.
    assign grant_d_c = d_req && (!i_req || (last_grant == OWN_I));
`else
    assign grant_d_c = d_req;
`endif

    assign mem_addr  = cmd.addr;
    assign mem_wdata = cmd.wdata;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            owner   <= OWN_I;
            cnt     <= '0;
            cmd     <= '0;
            mem_we  <= 1'b0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            busy    <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
`ifdef MEMARB_RR_EN
            last_grant <= OWN_I;
`endif
        end else begin
            mem_we <= 1'b0;
            i_ack  <= 1'b0;
            d_ack  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        state <= ACCESS;
                        busy  <= 1'b1;
                        cnt   <= CNT_LOAD;
                        if (grant_d_c) begin
                            owner  <= OWN_D;
                            cmd    <= '{addr: d_addr, wdata: d_wdata};
                            mem_we <= d_we;
                        end else begin
                            owner  <= OWN_I;
                            cmd    <= '{addr: i_addr, wdata: '0};
                        end
`ifdef MEMARB_RR_EN
                        last_grant <= grant_d_c ? OWN_D : OWN_I;
`endif
                    end
                end
                ACCESS: begin
                    // Last access cycle: capture read data and raise the owner's ack.
                    if (cnt == '0) begin
                        state <= RESP;
                        if (owner == OWN_D) begin
                            d_rdata <= mem_rdata;
                            d_ack   <= 1'b1;
                        end else begin
                            i_rdata <= mem_rdata;
                            i_ack   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios on MEM_LAT=1 and MEM_LAT=3 instances,
// then random traffic against a transaction-level timing model. Honours MEMARB_RR_EN.
module tb_mem_port_arbiter;

    logic        CLK;
    logic        RST;
    logic        i_req     [2];
    logic [31:0] i_addr    [2];
    logic        i_ack     [2];
    logic [31:0] i_rdata   [2];
    logic        d_req     [2];
    logic        d_we      [2];
    logic [31:0] d_addr    [2];
    logic [31:0] d_wdata   [2];
    logic        d_ack     [2];
    logic [31:0] d_rdata   [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic        mem_we    [2];
    logic [31:0] mem_rdata [2];
    logic        busy      [2];

    int n_pass  = 0;
    int n_total = 0;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        mem_port_arbiter #(.MEM_LAT((k == 0) ? 1 : 3)) u_dut (
            .CLK       (CLK),
            .RST       (RST),
            .i_req     (i_req[k]),
            .i_addr    (i_addr[k]),
            .i_ack     (i_ack[k]),
            .i_rdata   (i_rdata[k]),
            .d_req     (d_req[k]),
            .d_we      (d_we[k]),
            .d_addr    (d_addr[k]),
            .d_wdata   (d_wdata[k]),
            .d_ack     (d_ack[k]),
            .d_rdata   (d_rdata[k]),
            .mem_addr  (mem_addr[k]),
            .mem_wdata (mem_wdata[k]),
            .mem_we    (mem_we[k]),
            .mem_rdata (mem_rdata[k]),
            .busy      (busy[k])
        );
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Contention rule: fixed data priority, or the side not granted last.
    function automatic bit pick_d(input bit last_was_d);
`ifdef MEMARB_RR_EN
        return !last_was_d;
`else
        return 1'b1;
`endif
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // One transaction from an IDLE sample edge through the return to IDLE.
    task automatic txn(input int k, input logic [31:0] addr, input bit is_d, input string tag);
        tick();
        chk1({tag, "_busy"}, busy[k], 1'b1);
        chk ({tag, "_addr"}, mem_addr[k], addr);
        chk1({tag, "_early_iack"}, i_ack[k], 1'b0);
        chk1({tag, "_early_dack"}, d_ack[k], 1'b0);
        repeat (lat(k) - 1) begin
            tick();
            chk1({tag, "_wait_iack"}, i_ack[k], 1'b0);
            chk1({tag, "_wait_dack"}, d_ack[k], 1'b0);
        end
        tick();
        chk1({tag, "_dack"}, d_ack[k], is_d);
        chk1({tag, "_iack"}, i_ack[k], !is_d);
        tick();
        chk1({tag, "_idle"}, busy[k], 1'b0);
        chk1({tag, "_iack_off"}, i_ack[k], 1'b0);
        chk1({tag, "_dack_off"}, d_ack[k], 1'b0);
    endtask

    // Random-phase model state, per instance.
    int          m_grant [2];
    int          m_ack   [2];
    int          m_free  [2];
    bit          m_own_d [2];
    bit          m_store [2];
    bit          m_last_d[2];
    bit          m_dr_ok [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [31:0] m_ir    [2];
    logic [31:0] m_dr    [2];
    bit          i_fl    [2];
    bit          d_fl    [2];

    initial begin
        bit          s_rst;
        bit          s_i  [2];
        bit          s_d  [2];
        bit          s_we [2];
        logic [31:0] s_ia [2];
        logic [31:0] s_da [2];
        logic [31:0] s_dw [2];
        logic [31:0] s_mr [2];
        bit          gd;
        bit          ack_i;
        bit          ack_d;
        bit          rst_now;

        RST = 1'b1;
        for (int k = 0; k < 2; k++) begin
            i_req[k] = 1'b0; i_addr[k] = '0; d_req[k] = 1'b0; d_we[k] = 1'b0;
            d_addr[k] = '0; d_wdata[k] = '0; mem_rdata[k] = '0;
        end
        tick();
        tick();
        RST = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk1("rst_busy", busy[k], 1'b0);
            chk1("rst_iack", i_ack[k], 1'b0);
            chk1("rst_dack", d_ack[k], 1'b0);
            chk1("rst_we", mem_we[k], 1'b0);
            chk ("rst_addr", mem_addr[k], 32'h0);
            chk ("rst_wdata", mem_wdata[k], 32'h0);
            chk ("rst_irdata", i_rdata[k], 32'h0);
            chk ("rst_drdata", d_rdata[k], 32'h0);
        end

        // Single fetch, MEM_LAT=1; address change after grant must be ignored.
        i_addr[0] = 32'h10; mem_rdata[0] = 32'h0050_0093; i_req[0] = 1'b1;
        tick();
        chk1("a_busy", busy[0], 1'b1);
        chk ("a_addr", mem_addr[0], 32'h10);
        chk1("a_we", mem_we[0], 1'b0);
        chk1("a_early", i_ack[0], 1'b0);
        i_addr[0] = 32'hFFFF_FFF0;
        tick();
        chk1("a_iack", i_ack[0], 1'b1);
        chk1("a_dack", d_ack[0], 1'b0);
        chk ("a_rdata", i_rdata[0], 32'h0050_0093);
        chk ("a_addr_hold", mem_addr[0], 32'h10);
        i_req[0] = 1'b0; mem_rdata[0] = '0;
        tick();
        chk1("a_iack_off", i_ack[0], 1'b0);
        chk1("a_idle", busy[0], 1'b0);
        chk ("a_rdata_hold", i_rdata[0], 32'h0050_0093);

        // Single store: one-cycle write strobe, then one ack.
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h40; d_wdata[0] = 32'hDEAD_BEEF;
        tick();
        chk1("b_we", mem_we[0], 1'b1);
        chk ("b_addr", mem_addr[0], 32'h40);
        chk ("b_wdata", mem_wdata[0], 32'hDEAD_BEEF);
        chk1("b_early", d_ack[0], 1'b0);
        d_we[0] = 1'b0; d_wdata[0] = '0;
        tick();
        chk1("b_we_off", mem_we[0], 1'b0);
        chk1("b_dack", d_ack[0], 1'b1);
        chk1("b_iack", i_ack[0], 1'b0);
        d_req[0] = 1'b0;
        tick();
        chk1("b_dack_off", d_ack[0], 1'b0);
        chk1("b_we_off2", mem_we[0], 1'b0);
        chk1("b_idle", busy[0], 1'b0);
        tick();
        chk1("b_we_off3", mem_we[0], 1'b0);

        // Contention from a fresh reset, both requests held.
        RST = 1'b1;
        tick();
        RST = 1'b0;
        i_addr[0] = 32'h100; i_req[0] = 1'b1;
        d_addr[0] = 32'h200; d_we[0] = 1'b0; d_req[0] = 1'b1;
        mem_rdata[0] = 32'hA5A5_0001;
        txn(0, 32'h200, 1'b1, "c1");
`ifdef MEMARB_RR_EN
        txn(0, 32'h100, 1'b0, "c2_rr");
`else
        txn(0, 32'h200, 1'b1, "c2_fix");
        d_req[0] = 1'b0;
        txn(0, 32'h100, 1'b0, "c3_fix");
`endif
        i_req[0] = 1'b0; d_req[0] = 1'b0;
        tick();
        chk1("c_idle", busy[0], 1'b0);

        // MEM_LAT=3 load; read data changes every cycle, third access value is kept.
        d_addr[1] = 32'h80; d_we[1] = 1'b0; d_req[1] = 1'b1; mem_rdata[1] = 32'h1111_0000;
        tick();
        chk1("d_busy", busy[1], 1'b1);
        chk ("d_addr", mem_addr[1], 32'h80);
        chk1("d_ack1", d_ack[1], 1'b0);
        mem_rdata[1] = 32'h1111_0001;
        tick();
        chk1("d_ack2", d_ack[1], 1'b0);
        mem_rdata[1] = 32'h1111_0002;
        tick();
        chk1("d_ack3", d_ack[1], 1'b0);
        mem_rdata[1] = 32'h1111_0003;
        tick();
        chk1("d_ack", d_ack[1], 1'b1);
        chk ("d_rdata", d_rdata[1], 32'h1111_0003);
        mem_rdata[1] = 32'h1111_0004; d_req[1] = 1'b0;
        tick();
        chk1("d_ack_off", d_ack[1], 1'b0);
        chk1("d_idle", busy[1], 1'b0);
        chk ("d_rdata_hold", d_rdata[1], 32'h1111_0003);

        // Reset in the second access cycle abandons the fetch.
        i_addr[1] = 32'h300; i_req[1] = 1'b1;
        tick();
        chk1("e_busy1", busy[1], 1'b1);
        tick();
        chk1("e_busy2", busy[1], 1'b1);
        chk1("e_iack2", i_ack[1], 1'b0);
        RST = 1'b1; i_req[1] = 1'b0;
        tick();
        RST = 1'b0;
        chk1("e_rst_busy", busy[1], 1'b0);
        chk1("e_rst_iack", i_ack[1], 1'b0);
        chk ("e_rst_addr", mem_addr[1], 32'h0);
        chk ("e_rst_drdata", d_rdata[1], 32'h0);
        repeat (4) begin
            tick();
            chk1("e_no_iack", i_ack[1], 1'b0);
            chk1("e_no_busy", busy[1], 1'b0);
        end
        i_addr[1] = 32'h304; mem_rdata[1] = 32'hCAFE_0001; i_req[1] = 1'b1;
        txn(1, 32'h304, 1'b0, "e_new");
        chk ("e_new_rdata", i_rdata[1], 32'hCAFE_0001);
        i_req[1] = 1'b0;

        // Random traffic against the transaction-level model.
        RST = 1'b1;
        for (int k = 0; k < 2; k++) begin
            i_req[k] = 1'b0; d_req[k] = 1'b0; i_fl[k] = 1'b0; d_fl[k] = 1'b0;
            m_grant[k] = -1; m_ack[k] = -1; m_free[k] = 0;
        end
        for (int c = 0; c < 800; c++) begin
            s_rst = RST;
            for (int k = 0; k < 2; k++) begin
                s_i[k] = i_req[k]; s_d[k] = d_req[k]; s_we[k] = d_we[k];
                s_ia[k] = i_addr[k]; s_da[k] = d_addr[k]; s_dw[k] = d_wdata[k];
                s_mr[k] = mem_rdata[k];
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                if (s_rst) begin
                    m_grant[k] = -1; m_ack[k] = -1; m_free[k] = c + 1;
                    m_addr[k] = '0; m_ir[k] = '0; m_dr[k] = '0;
                    m_dr_ok[k] = 1'b1; m_last_d[k] = 1'b0; m_store[k] = 1'b0;
                end else begin
                    if (c == m_ack[k]) begin
                        if (!m_own_d[k]) m_ir[k] = s_mr[k];
                        else if (m_store[k]) m_dr_ok[k] = 1'b0;
                        else begin m_dr[k] = s_mr[k]; m_dr_ok[k] = 1'b1; end
                    end
                    if (c >= m_free[k] && (s_i[k] || s_d[k])) begin
                        gd = s_d[k] && (!s_i[k] || pick_d(m_last_d[k]));
                        m_own_d[k]  = gd;
                        m_store[k]  = gd && s_we[k];
                        m_addr[k]   = gd ? s_da[k] : s_ia[k];
                        m_wdata[k]  = s_dw[k];
                        m_grant[k]  = c;
                        m_ack[k]    = c + lat(k);
                        m_free[k]   = c + lat(k) + 2;
                        m_last_d[k] = gd;
                        if (gd) d_fl[k] = 1'b1; else i_fl[k] = 1'b1;
                    end
                end
                ack_i = (c == m_ack[k]) && !m_own_d[k];
                ack_d = (c == m_ack[k]) && m_own_d[k];
                chk1("r_busy", busy[k], (m_grant[k] >= 0) && (c >= m_grant[k]) && (c <= m_ack[k]));
                chk1("r_iack", i_ack[k], ack_i);
                chk1("r_dack", d_ack[k], ack_d);
                chk1("r_we", mem_we[k], (c == m_grant[k]) && m_store[k]);
                chk ("r_addr", mem_addr[k], m_addr[k]);
                if ((c == m_grant[k]) && m_store[k]) chk("r_wdata", mem_wdata[k], m_wdata[k]);
                chk ("r_irdata", i_rdata[k], m_ir[k]);
                if (m_dr_ok[k]) chk("r_drdata", d_rdata[k], m_dr[k]);
                if (ack_i) begin
                    i_fl[k] = 1'b0;
                    if ($urandom_range(0, 1) == 0) i_req[k] = 1'b0;
                end
                if (ack_d) begin
                    d_fl[k] = 1'b0;
                    if ($urandom_range(0, 1) == 0) d_req[k] = 1'b0;
                end
            end
            rst_now = ($urandom_range(0, 99) == 0);
            RST = rst_now;
            for (int k = 0; k < 2; k++) begin
                if (rst_now) begin
                    i_req[k] = 1'b0; d_req[k] = 1'b0; i_fl[k] = 1'b0; d_fl[k] = 1'b0;
                end else begin
                    if (i_fl[k]) begin
                        i_addr[k] = $urandom;
                        if ($urandom_range(0, 7) == 0) i_req[k] = 1'b0;
                    end else if (!i_req[k] && $urandom_range(0, 1) == 1) begin
                        i_req[k] = 1'b1; i_addr[k] = $urandom;
                    end
                    if (d_fl[k]) begin
                        d_addr[k] = $urandom; d_wdata[k] = $urandom; d_we[k] = 1'($urandom_range(0, 1));
                        if ($urandom_range(0, 7) == 0) d_req[k] = 1'b0;
                    end else if (!d_req[k] && $urandom_range(0, 1) == 1) begin
                        d_req[k] = 1'b1; d_addr[k] = $urandom; d_wdata[k] = $urandom;
                        d_we[k] = 1'($urandom_range(0, 1));
                    end
                end
                mem_rdata[k] = $urandom;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
